// File: rtl/cordic_pkg.sv
// Shared mode/state encodings, hyperbolic repeat list, gain constants and
// elaboration-time helpers for the iterative CORDIC engine.
package cordic_pkg;

    typedef enum logic [1:0] {
        MODE_HYP  = 2'b00,
        MODE_CIRC = 2'b01,
        MODE_LIN  = 2'b10
    } cordic_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } cordic_state_e;

    localparam int HYP_REPEAT_NUM = 3;
    localparam int HYP_REPEAT [HYP_REPEAT_NUM] = '{4, 13, 40};

    localparam real CORDIC_KC = 1.6467602581210654;
    localparam real CORDIC_KH = 0.8281593609602157;

    // Series sums are kept with this many fractional bits before rounding.
    localparam int LUT_FRAC = 60;

    function automatic logic cordic_is_repeat(input int shift);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < HYP_REPEAT_NUM; i++) begin
            if (HYP_REPEAT[i] == shift) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic int cordic_num_iter(input logic [1:0] mode, input int iter);
        int n;
        n = iter;
        if (mode == MODE_HYP) begin
            for (int i = 0; i < HYP_REPEAT_NUM; i++) begin
                if (HYP_REPEAT[i] <= iter) n++;
            end
        end
        return n;
    endfunction

    // atan/atanh via their Taylor series at 2^-shift, rounded to nearest Q3.(width-3).
    function automatic logic [63:0] cordic_lut(input logic [1:0] mode, input int shift,
                                               input int width);
        logic [63:0] acc;
        logic [63:0] term;
        int          e;
        acc = '0;
        if (mode == MODE_LIN) begin
            if (shift <= LUT_FRAC) acc = 64'd1 << (LUT_FRAC - shift);
        end else if (mode == MODE_HYP) begin
            if (shift > 0) begin
                for (int k = 0; k < 32; k++) begin
                    e = LUT_FRAC - (2 * k + 1) * shift;
                    if (e >= 0) begin
                        term = (64'd1 << e) / 64'(2 * k + 1);
                        acc  = acc + term;
                    end
                end
            end
        end else if (shift == 0) begin
            acc = 64'h0C90_FDAA_2216_8C23;
        end else begin
            for (int k = 0; k < 32; k++) begin
                e = LUT_FRAC - (2 * k + 1) * shift;
                if (e >= 0) begin
                    term = (64'd1 << e) / 64'(2 * k + 1);
                    acc  = (k % 2 == 1) ? acc - term : acc + term;
                end
            end
        end
        return (acc + (64'd1 << (LUT_FRAC - width + 2))) >> (LUT_FRAC - width + 3);
    endfunction

endpackage

// File: rtl/cordic_step.sv
// Combinational CORDIC micro-rotation for circular, hyperbolic and linear
// coordinates; all terms use the pre-update x, y, z.
module cordic_step
    import cordic_pkg::*;
#(
    parameter int p_WIDTH = 16,
    parameter int p_SW    = 5
) (
    input  logic signed [p_WIDTH-1:0] x,
    input  logic signed [p_WIDTH-1:0] y,
    input  logic signed [p_WIDTH-1:0] z,
    input  logic                      d,
    input  logic [1:0]                mode,
    input  logic [p_SW-1:0]           shift,
    input  logic signed [p_WIDTH-1:0] lut,
    output logic signed [p_WIDTH-1:0] x_next,
    output logic signed [p_WIDTH-1:0] y_next,
    output logic signed [p_WIDTH-1:0] z_next
);

    logic signed [p_WIDTH-1:0] x_sh;
    logic signed [p_WIDTH-1:0] y_sh;

    always_comb begin
        x_sh   = x >>> shift;
        y_sh   = y >>> shift;
        y_next = d ? y + x_sh : y - x_sh;
        z_next = d ? z - lut : z + lut;
        case (mode)
            MODE_HYP: x_next = d ? x + y_sh : x - y_sh;
            MODE_LIN: x_next = x;
            default:  x_next = d ? x - y_sh : x + y_sh;
        endcase
    end

endmodule

// File: rtl/cordic_iter_engine.sv
// Iterative multi-mode CORDIC engine: one reused micro-rotation per cycle,
// operands and results exchanged through valid/ready handshakes.
module cordic_iter_engine
    import cordic_pkg::*;
#(
    parameter int p_WIDTH = 16,
    parameter int p_ITER  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [p_WIDTH-1:0] i_x,
    input  logic [p_WIDTH-1:0] i_y,
    input  logic [p_WIDTH-1:0] i_z,
    input  logic [1:0]         i_mode,
    input  logic               i_vectoring,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [p_WIDTH-1:0] o_x,
    output logic [p_WIDTH-1:0] o_y,
    output logic [p_WIDTH-1:0] o_z
);

    localparam int SW    = $clog2(p_ITER + 1);
    localparam int N_STD = cordic_num_iter(MODE_CIRC, p_ITER);
    localparam int N_HYP = cordic_num_iter(MODE_HYP, p_ITER);
    localparam int CW    = $clog2(N_HYP + 1);

    cordic_state_e             state;
    cordic_state_e             state_next;
    cordic_mode_e              mode_q;
    cordic_mode_e              mode_in;
    logic                      vec_q;
    logic                      rep_q;
    logic                      d;
    logic                      repeat_now;
    logic                      last_iter;
    logic [CW-1:0]             cnt_q;
    logic [SW-1:0]             shift_q;
    logic signed [p_WIDTH-1:0] x_q, y_q, z_q;
    logic signed [p_WIDTH-1:0] x_next, y_next, z_next;
    logic signed [p_WIDTH-1:0] lut;
    logic [p_WIDTH-1:0]        lut_circ [p_ITER+1];
    logic [p_WIDTH-1:0]        lut_hyp  [p_ITER+1];
    logic [p_WIDTH-1:0]        lut_lin  [p_ITER+1];

    for (genvar g = 0; g <= p_ITER; g++) begin : g_lut
        assign lut_circ[g] = p_WIDTH'(cordic_lut(MODE_CIRC, g, p_WIDTH));
        assign lut_hyp[g]  = p_WIDTH'(cordic_lut(MODE_HYP, g, p_WIDTH));
        assign lut_lin[g]  = p_WIDTH'(cordic_lut(MODE_LIN, g, p_WIDTH));
    end

    always_comb begin
        mode_in    = (i_mode == 2'b11) ? MODE_CIRC : cordic_mode_e'(i_mode);
        d          = vec_q ? y_q[p_WIDTH-1] : ~z_q[p_WIDTH-1];
        repeat_now = (mode_q == MODE_HYP) && !rep_q && cordic_is_repeat(int'(shift_q));
        last_iter  = (mode_q == MODE_HYP) ? (cnt_q == CW'(N_HYP - 1))
                                          : (cnt_q == CW'(N_STD - 1));
        case (mode_q)
            MODE_HYP: lut = $signed(lut_hyp[shift_q]);
            MODE_LIN: lut = $signed(lut_lin[shift_q]);
            default:  lut = $signed(lut_circ[shift_q]);
        endcase
    end

    cordic_step #(
        .p_WIDTH (p_WIDTH),
        .p_SW    (SW)
    ) u_step (
        .x      (x_q),
        .y      (y_q),
        .z      (z_q),
        .d      (d),
        .mode   (mode_q),
        .shift  (shift_q),
        .lut    (lut),
        .x_next (x_next),
        .y_next (y_next),
        .z_next (z_next)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        case (state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (last_iter) state_next = ST_DONE;
            end
            ST_DONE: begin
                o_valid = 1'b1;
                if (i_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Hyperbolic repeats hold the shift for one extra step, flagged by rep_q.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            mode_q  <= MODE_CIRC;
            vec_q   <= 1'b0;
            rep_q   <= 1'b0;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        x_q     <= $signed(i_x);
                        y_q     <= $signed(i_y);
                        z_q     <= $signed(i_z);
                        mode_q  <= mode_in;
                        vec_q   <= i_vectoring;
                        rep_q   <= 1'b0;
                        cnt_q   <= '0;
                        shift_q <= (mode_in == MODE_HYP) ? SW'(1) : '0;
                    end
                end
                ST_RUN: begin
                    x_q   <= x_next;
                    y_q   <= y_next;
                    z_q   <= z_next;
                    cnt_q <= cnt_q + CW'(1);
                    if (repeat_now) begin
                        rep_q <= 1'b1;
                    end else begin
                        rep_q   <= 1'b0;
                        shift_q <= shift_q + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_x = x_q;
    assign o_y = y_q;
    assign o_z = z_q;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Self-checking bench for cordic_iter_engine: directed cases, handshake and
// reset behaviour, plus random operands against a real-math reference model.
module tb_cordic_iter_engine;

    localparam int  W     = 16;
    localparam int  ITER  = 16;
    localparam real SCALE = 8192.0;

    logic                clk = 1'b0;
    logic                rstN;
    logic                inValid;
    logic                outReady;
    logic signed [W-1:0] inX, inY, inZ;
    logic [1:0]          inMode;
    logic                inVectoring;
    logic                outValid;
    logic                inReady;
    logic signed [W-1:0] outX, outY, outZ;

    int testsRun    = 0;
    int testsFailed = 0;

    cordic_iter_engine #(
        .p_WIDTH (W),
        .p_ITER  (ITER)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_valid     (inValid),
        .o_ready     (outReady),
        .i_x         (inX),
        .i_y         (inY),
        .i_z         (inZ),
        .i_mode      (inMode),
        .i_vectoring (inVectoring),
        .o_valid     (outValid),
        .i_ready     (inReady),
        .o_x         (outX),
        .o_y         (outY),
        .o_z         (outZ)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkNear(input string tag, input longint observed, input longint target,
                             input longint tol);
        longint diff;
        diff = observed - target;
        if (diff < 0) diff = -diff;
        checkOutput($sformatf("%s (value %0d, want %0d +-%0d)", tag, observed, target, tol),
                    longint'(diff <= tol), 1);
    endtask

    function automatic int wrapW(input int v);
        logic signed [W-1:0] t;
        t = W'(v);
        return int'(t);
    endfunction

    function automatic int lutValue(input logic [1:0] mode, input int s);
        real t;
        real v;
        t = $pow(2.0, -1.0 * s);
        if (mode == 2'b00)      v = $atanh(t);
        else if (mode == 2'b10) v = t;
        else                    v = $atan(t);
        return int'($floor(v * SCALE + 0.5));
    endfunction

    // Reference: build the shift schedule as a list, then apply the rotation rules with wrapping.
    task automatic modelCordic(input logic signed [W-1:0] x0, y0, z0, input logic [1:0] mode,
                               input logic vec, output logic signed [W-1:0] xr, yr, zr,
                               output int n);
        int shifts[$];
        int x, y, z, xs, ys, l, nx, ny, nz;
        bit d;
        if (mode == 2'b00) begin
            for (int s = 1; s <= ITER; s++) begin
                shifts.push_back(s);
                if (s == 4 || s == 13 || s == 40) shifts.push_back(s);
            end
        end else begin
            for (int s = 0; s < ITER; s++) shifts.push_back(s);
        end
        x = x0;
        y = y0;
        z = z0;
        foreach (shifts[i]) begin
            l  = lutValue(mode, shifts[i]);
            d  = vec ? (y < 0) : (z >= 0);
            xs = x >>> shifts[i];
            ys = y >>> shifts[i];
            if (mode == 2'b00)      nx = d ? x + ys : x - ys;
            else if (mode == 2'b10) nx = x;
            else                    nx = d ? x - ys : x + ys;
            ny = d ? y + xs : y - xs;
            nz = d ? z - l : z + l;
            x  = wrapW(nx);
            y  = wrapW(ny);
            z  = wrapW(nz);
        end
        xr = W'(x);
        yr = W'(y);
        zr = W'(z);
        n  = shifts.size();
    endtask

    task automatic applyStimulus(input string name, input logic signed [W-1:0] x, y, z,
                                 input logic [1:0] mode, input logic vec, input int holdCycles,
                                 input bit pulseInRun, output logic signed [W-1:0] gotX, gotY,
                                 gotZ, output int latency);
        logic signed [W-1:0] ex, ey, ez;
        int n;
        int waitCount;
        modelCordic(x, y, z, mode, vec, ex, ey, ez, n);
        waitCount = 0;
        while (!outReady && waitCount < 50) begin
            @(posedge clk);
            #1;
            waitCount++;
        end
        checkOutput({name, " ready before accept"}, longint'(outReady), 1);
        inX         = x;
        inY         = y;
        inZ         = z;
        inMode      = mode;
        inVectoring = vec;
        inValid     = 1'b1;
        @(posedge clk);
        #1;
        inValid     = 1'b0;
        inX         = W'($urandom);
        inY         = W'($urandom);
        inZ         = W'($urandom);
        inMode      = 2'($urandom);
        inVectoring = 1'($urandom);
        latency     = 0;
        while (!outValid && latency < 100) begin
            if (pulseInRun && latency == 3) begin
                inValid = 1'b1;
                checkOutput({name, " ready low in RUN"}, longint'(outReady), 0);
            end else begin
                inValid = 1'b0;
            end
            @(posedge clk);
            #1;
            latency++;
        end
        inValid = 1'b0;
        gotX    = outX;
        gotY    = outY;
        gotZ    = outZ;
        checkOutput({name, " latency"}, latency, n);
        checkOutput({name, " x"}, outX, ex);
        checkOutput({name, " y"}, outY, ey);
        checkOutput({name, " z"}, outZ, ez);
        for (int c = 0; c < holdCycles; c++) begin
            @(posedge clk);
            #1;
            checkOutput({name, " hold valid"}, longint'(outValid), 1);
            checkOutput({name, " hold ready"}, longint'(outReady), 0);
            checkOutput({name, " hold x"}, outX, ex);
            checkOutput({name, " hold z"}, outZ, ez);
        end
        inReady = 1'b1;
        @(posedge clk);
        #1;
        inReady = 1'b0;
        checkOutput({name, " ready after handoff"}, longint'(outReady), 1);
        checkOutput({name, " valid after handoff"}, longint'(outValid), 0);
    endtask

    initial begin
        logic signed [W-1:0] rx, ry, rz;
        int lat;
        int seen;
        rstN        = 1'b0;
        inValid     = 1'b0;
        inReady     = 1'b0;
        inX         = '0;
        inY         = '0;
        inZ         = '0;
        inMode      = 2'b01;
        inVectoring = 1'b0;
        #12;
        checkOutput("reset o_ready", longint'(outReady), 1);
        checkOutput("reset o_valid", longint'(outValid), 0);
        checkOutput("reset o_x", outX, 0);
        checkOutput("reset o_y", outY, 0);
        checkOutput("reset o_z", outZ, 0);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus("circRot", 16'sd4975, 16'sd0, 16'sd6434, 2'b01, 1'b0, 5, 1'b1,
                      rx, ry, rz, lat);
        checkOutput("circRot latency 16", lat, 16);
        checkNear("circRot o_x", rx, 5793, 4);
        checkNear("circRot o_y", ry, 5793, 4);
        checkNear("circRot o_z", rz, 0, 4);

        applyStimulus("circVec", 16'sd8192, 16'sd8192, 16'sd0, 2'b01, 1'b1, 0, 1'b0,
                      rx, ry, rz, lat);
        checkNear("circVec o_z", rz, 6434, 4);
        checkNear("circVec o_x", rx, 19079, 8);
        checkNear("circVec o_y", ry, 0, 4);

        applyStimulus("hypRot", 16'sd9891, 16'sd0, 16'sd4096, 2'b00, 1'b0, 2, 1'b1,
                      rx, ry, rz, lat);
        checkOutput("hypRot latency 18", lat, 18);
        checkNear("hypRot o_x", rx, 9237, 6);
        checkNear("hypRot o_y", ry, 4269, 6);

        applyStimulus("linVec", 16'sd8192, 16'sd4096, 16'sd0, 2'b10, 1'b1, 1, 1'b0,
                      rx, ry, rz, lat);
        checkNear("linVec o_z", rz, 4096, 2);
        checkNear("linVec o_y", ry, 0, 2);
        checkOutput("linVec o_x exact", rx, 8192);

        // Abort an operation after seven iterations with an asynchronous reset.
        inX         = 16'sd4975;
        inY         = 16'sd0;
        inZ         = 16'sd6434;
        inMode      = 2'b01;
        inVectoring = 1'b0;
        inValid     = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        rstN = 1'b0;
        #1;
        checkOutput("midRun reset o_x", outX, 0);
        checkOutput("midRun reset o_y", outY, 0);
        checkOutput("midRun reset o_z", outZ, 0);
        checkOutput("midRun reset o_ready", longint'(outReady), 1);
        checkOutput("midRun reset o_valid", longint'(outValid), 0);
        @(negedge clk);
        rstN = 1'b1;
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (outValid) seen++;
        end
        checkOutput("midRun reset no o_valid", seen, 0);
        applyStimulus("afterReset", 16'sd8192, 16'sd8192, 16'sd0, 2'b01, 1'b1, 0, 1'b0,
                      rx, ry, rz, lat);

        for (int i = 0; i < 24; i++) begin
            applyStimulus($sformatf("rand%0d", i), W'($urandom), W'($urandom), W'($urandom),
                          2'($urandom), 1'($urandom), $urandom_range(0, 3),
                          1'($urandom), rx, ry, rz, lat);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
